// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-MM master arbiter.
// Provides state enum, width helpers and the round-robin picker.
package avalon_arb_pkg;

  typedef enum logic {ARB, GRANT} arb_state_t;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_ID_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req scanning from last+1, wrapping at n.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [MAX_ID_W-1:0]    last,
    input int unsigned            n
  );
    rr_pick_t            r;
    int unsigned         idx;
    logic [MAX_ID_W-1:0] sel;
    r = '0;
    for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
      idx = (32'(last) + k) % n;
      sel = idx[MAX_ID_W-1:0];
      if (k <= n && !r.valid && req[sel]) begin
        r.valid = 1'b1;
        r.idx   = sel;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/avalon_arb_pending_fifo.sv
// Owner FIFO of accepted reads awaiting their readdatavalid beat.
// push/din in, pop in, full/empty/head out; sync active-low flush.
module avalon_arb_pending_fifo
  import avalon_arb_pkg::*;
#(
  parameter int ID_W  = 1,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [ID_W-1:0] din,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [ID_W-1:0] head
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only safe when a pop frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among masters.
// m_* per-master ports, s_* slave port, err_unexpected_rdv sticky.
module avalon_master_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]             m_read,
  input  logic [NUM_MASTERS-1:0]             m_write,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]             m_waitrequest,
  output logic [NUM_MASTERS-1:0]             m_readdatavalid,
  output logic [DATA_W-1:0]                  m_readdata,
  output logic [ADDR_W-1:0]                  s_address,
  output logic                               s_read,
  output logic                               s_write,
  output logic [DATA_W-1:0]                  s_writedata,
  input  logic                               s_waitrequest,
  input  logic                               s_readdatavalid,
  input  logic [DATA_W-1:0]                  s_readdata,
  output logic                               err_unexpected_rdv
);

  localparam int ID_W = id_width(NUM_MASTERS);

  arb_state_t             state;
  logic [ID_W-1:0]        owner;
  logic [ID_W-1:0]        last_grant;
  logic [NUM_MASTERS-1:0] eligible;
  logic [MAX_MASTERS-1:0] req_ext;
  logic [MAX_ID_W-1:0]    last_ext;
  rr_pick_t               pick;
  logic                   own_rd;
  logic                   own_wr;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ID_W-1:0]        fifo_head;

  // Reads wait while the owner FIFO is full; writes never do.
  assign eligible = m_write
                  | (m_read & {NUM_MASTERS{!fifo_full}});
  assign req_ext  = MAX_MASTERS'(eligible);
  assign last_ext = MAX_ID_W'(last_grant);
  assign pick     = rr_pick(req_ext, last_ext, NUM_MASTERS);

  // Write wins when a master raises both.
  assign own_wr = m_write[owner];
  assign own_rd = m_read[owner] && !m_write[owner];

  assign s_read      = (state == GRANT) && own_rd;
  assign s_write     = (state == GRANT) && own_wr;
  assign s_address   = m_address[owner];
  assign s_writedata = m_writedata[owner];
  assign m_readdata  = s_readdata;

  assign accept = (s_read || s_write) && !s_waitrequest;
  assign push   = accept && s_read;
  assign pop    = s_readdatavalid && !fifo_empty;

  always_comb begin
    m_waitrequest = '1;
    if (state == GRANT) begin
      m_waitrequest[owner] = s_waitrequest;
    end
  end

  always_comb begin
    m_readdatavalid = '0;
    if (pop) begin
      m_readdatavalid[fifo_head] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= ARB;
      owner              <= '0;
      last_grant         <= ID_W'(NUM_MASTERS - 1);
      err_unexpected_rdv <= 1'b0;
    end else begin
      if (s_readdatavalid && fifo_empty) begin
        err_unexpected_rdv <= 1'b1;
      end
      unique case (state)
        ARB: begin
          if (pick.valid) begin
            owner <= ID_W'(pick.idx);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            last_grant <= owner;
            state      <= ARB;
          end else if (!own_rd && !own_wr) begin
            // Owner withdrew: abandon the grant, no credit taken.
            state <= ARB;
          end
        end
      endcase
    end
  end

  avalon_arb_pending_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_PENDING)
  ) u_pending (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (owner),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Self-checking bench for avalon_master_arbiter (2 masters).
// Directed scenarios plus randomized traffic against a queue model.
module tb_avalon_master_arbiter;

  localparam int NM   = 2;
  localparam int MAXP = 4;

  logic             clk;
  logic             reset_n;
  logic [NM-1:0][31:0] m_address;
  logic [NM-1:0]    m_read;
  logic [NM-1:0]    m_write;
  logic [NM-1:0][31:0] m_writedata;
  logic [NM-1:0]    m_waitrequest;
  logic [NM-1:0]    m_readdatavalid;
  logic [31:0]      m_readdata;
  logic [31:0]      s_address;
  logic             s_read;
  logic             s_write;
  logic [31:0]      s_writedata;
  logic             s_waitrequest;
  logic             s_readdatavalid;
  logic [31:0]      s_readdata;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;

  avalon_master_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .m_address          (m_address),
    .m_read             (m_read),
    .m_write            (m_write),
    .m_writedata        (m_writedata),
    .m_waitrequest      (m_waitrequest),
    .m_readdatavalid    (m_readdatavalid),
    .m_readdata         (m_readdata),
    .s_address          (s_address),
    .s_read             (s_read),
    .s_write            (s_write),
    .s_writedata        (s_writedata),
    .s_waitrequest      (s_waitrequest),
    .s_readdatavalid    (s_readdatavalid),
    .s_readdata         (s_readdata),
    .err_unexpected_rdv (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_address       = '0;
    m_read          = '0;
    m_write         = '0;
    m_writedata     = '0;
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Hold one command until the master sees waitrequest low.
  task automatic do_cmd(input logic mi, input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] d);
    bit got;
    m_address[mi]   = a;
    m_writedata[mi] = d;
    m_write[mi]     = wr;
    m_read[mi]      = !wr;
    got = 0;
    for (int k = 0; k < 16 && !got; k++) begin
      #1;
      if (!m_waitrequest[mi]) got = 1;
      tick();
    end
    m_read[mi]  = 1'b0;
    m_write[mi] = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL do_cmd m%0d: accepted=0 required=1", mi);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    m_write[0] = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (s_read !== 1'b0 || s_write !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cmd: rd=%b wr=%b required 0 0",
               s_read, s_write);
    end
    n_cmp++;
    if (m_waitrequest !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_wait: got %b required 11",
               m_waitrequest);
    end
    n_cmp++;
    if (m_readdatavalid !== 2'b00 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rdv: rdv=%b err=%b required 00 0",
               m_readdatavalid, err);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    int nw;
    apply_reset();
    m_write[0]     = 1'b1;
    m_address[0]   = 32'h10;
    m_writedata[0] = 32'hDEADBEEF;
    s_waitrequest  = 1'b1;
    #1;
    n_cmp++;
    if (s_write !== 1'b0 || m_waitrequest !== 2'b11) begin
      n_bad++;
      $display("FAIL sw_arb: wr=%b wait=%b required 0 11",
               s_write, m_waitrequest);
    end
    nw = 0;
    for (int g = 0; g < 3; g++) begin
      tick();
      s_waitrequest = (g < 2);
      #1;
      if (s_write === 1'b1) nw++;
      n_cmp++;
      if (m_waitrequest !== {1'b1, (g < 2)}) begin
        n_bad++;
        $display("FAIL sw_wait g%0d: got %b required %b",
                 g, m_waitrequest, {1'b1, (g < 2)});
      end
      n_cmp++;
      if (s_address !== 32'h10 || s_writedata !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL sw_bus g%0d: a=%h d=%h required 10 deadbeef",
                 g, s_address, s_writedata);
      end
    end
    tick();
    m_write[0] = 1'b0;
    #1;
    n_cmp++;
    if (s_write !== 1'b0 || nw != 3) begin
      n_bad++;
      $display("FAIL sw_count: wr=%b cycles=%0d required 0 3",
               s_write, nw);
    end
  endtask

  task automatic test_round_robin();
    int ac_cyc[$];
    int ac_m[$];
    int ex_cyc[4] = '{1, 3, 5, 7};
    int ex_m[4]   = '{0, 1, 0, 1};
    logic [1:0] acc;
    apply_reset();
    m_write     = 2'b11;
    m_address   = {32'h200, 32'h100};
    m_writedata = {32'h2, 32'h1};
    for (int c = 0; c < 8; c++) begin
      #1;
      acc = m_write & ~m_waitrequest;
      if (acc == 2'b01) begin ac_cyc.push_back(c); ac_m.push_back(0); end
      if (acc == 2'b10) begin ac_cyc.push_back(c); ac_m.push_back(1); end
      if (acc == 2'b11) begin ac_cyc.push_back(c); ac_m.push_back(9); end
      tick();
    end
    m_write = 2'b00;
    n_cmp++;
    if (ac_cyc.size() != 4) begin
      n_bad++;
      $display("FAIL rr_count: got %0d grants required 4",
               ac_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ac_cyc[i] != ex_cyc[i] || ac_m[i] != ex_m[i]) begin
          n_bad++;
          $display("FAIL rr_grant%0d: m%0d@%0d required m%0d@%0d",
                   i, ac_m[i], ac_cyc[i], ex_m[i], ex_cyc[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_read_routing();
    logic [1:0]  erdv;
    logic [31:0] edat;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin m_read = 2'b10; m_address[1] = 32'h20; end
      if (c == 2) begin m_read = 2'b01; m_address[0] = 32'h24; end
      if (c == 4) m_read = 2'b00;
      s_readdatavalid = (c == 6) || (c == 8);
      s_readdata = (c == 6) ? 32'hAAAA : 32'hBBBB;
      #1;
      if (c == 1 || c == 3) begin
        n_cmp++;
        if (s_read !== 1'b1
            || s_address !== ((c == 1) ? 32'h20 : 32'h24)
            || m_waitrequest !== ((c == 1) ? 2'b01 : 2'b10)) begin
          n_bad++;
          $display("FAIL rt_issue c%0d: rd=%b a=%h wait=%b",
                   c, s_read, s_address, m_waitrequest);
        end
      end
      erdv = (c == 6) ? 2'b10 : (c == 8) ? 2'b01 : 2'b00;
      edat = (c == 6) ? 32'hAAAA : 32'hBBBB;
      n_cmp++;
      if (m_readdatavalid !== erdv
          || (erdv != 0 && m_readdata !== edat)) begin
        n_bad++;
        $display("FAIL rt_ret c%0d: rdv=%b d=%h required %b %h",
                 c, m_readdatavalid, m_readdata, erdv, edat);
      end
      tick();
    end
    s_readdatavalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit wgot;
    apply_reset();
    for (int i = 0; i < MAXP; i++) begin
      do_cmd(1'b0, 1'b0, 32'h1000 + 32'(i), 32'h0);
    end
    m_read[0]      = 1'b1;
    m_address[0]   = 32'h30;
    m_write[1]     = 1'b1;
    m_address[1]   = 32'h40;
    m_writedata[1] = 32'h5555;
    wgot = 0;
    for (int k = 0; k < 6 && !wgot; k++) begin
      #1;
      n_cmp++;
      if (m_waitrequest[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL ff_hold k%0d: wait0=%b required 1",
                 k, m_waitrequest[0]);
      end
      if (!m_waitrequest[1] && s_write && s_address == 32'h40)
        wgot = 1;
      tick();
    end
    m_write[1] = 1'b0;
    n_cmp++;
    if (!wgot) begin
      n_bad++;
      $display("FAIL ff_write: granted=0 required 1");
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (s_read !== 1'b0 || m_waitrequest[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL ff_block k%0d: rd=%b wait0=%b required 0 1",
                 k, s_read, m_waitrequest[0]);
      end
      tick();
    end
    s_readdatavalid = 1'b1;
    s_readdata      = 32'h1234;
    #1;
    n_cmp++;
    if (m_readdatavalid !== 2'b01) begin
      n_bad++;
      $display("FAIL ff_pop: rdv=%b required 01", m_readdatavalid);
    end
    tick();
    s_readdatavalid = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (s_read !== 1'b1 || s_address !== 32'h30
        || m_waitrequest[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL ff_regrant: rd=%b a=%h wait0=%b req 1 30 0",
               s_read, s_address, m_waitrequest[0]);
    end
    tick();
    m_read[0] = 1'b0;
  endtask

  task automatic test_unexpected();
    apply_reset();
    s_readdatavalid = 1'b1;
    #1;
    n_cmp++;
    if (m_readdatavalid !== 2'b00 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL ue_same: rdv=%b err=%b required 00 0",
               m_readdatavalid, err);
    end
    tick();
    s_readdatavalid = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL ue_set: err=%b required 1", err);
    end
    repeat (3) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL ue_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_cmd(1'b0, 1'b0, 32'h50, 32'h0);
    do_cmd(1'b1, 1'b0, 32'h54, 32'h0);
    s_waitrequest  = 1'b1;
    m_write[0]     = 1'b1;
    m_address[0]   = 32'h58;
    tick();
    #1;
    n_cmp++;
    if (s_write !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_grant: wr=%b required 1", s_write);
    end
    reset_n = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (s_read !== 1'b0 || s_write !== 1'b0
        || m_waitrequest !== 2'b11 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_after: rd=%b wr=%b wait=%b err=%b",
               s_read, s_write, m_waitrequest, err);
    end
    reset_n       = 1'b1;
    m_write[0]    = 1'b0;
    s_waitrequest = 1'b0;
    tick();
    s_readdatavalid = 1'b1;
    #1;
    n_cmp++;
    if (m_readdatavalid !== 2'b00) begin
      n_bad++;
      $display("FAIL rm_late: rdv=%b required 00", m_readdatavalid);
    end
    tick();
    s_readdatavalid = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_err: err=%b required 1", err);
    end
  endtask

  // Masters replay command lists; slave stalls and returns reads
  // in order after random latency. Model: accepted-command and
  // outstanding-read queues.
  task automatic test_random();
    localparam int N = 40;
    logic [31:0] ca [2][N];
    logic [31:0] cd [2][N];
    bit          cw [2][N];
    int          hd [2];
    int          gp [2];
    int          due[$];
    int          rm[$];
    logic [31:0] rdq[$];
    int          lastdue, nacc, who, j, d;
    bit          sacc, rdv, done;
    logic [1:0]  erdv;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      hd[i] = 0;
      gp[i] = $urandom_range(0, 2);
      for (int k = 0; k < N; k++) begin
        cw[i][k] = 1'($urandom_range(0, 1));
        ca[i][k] = $urandom;
        cd[i][k] = $urandom;
      end
    end
    lastdue = 0;
    done    = 0;
    for (int cy = 0; cy < 3000 && !done; cy++) begin
      for (int i = 0; i < 2; i++) begin
        if (gp[i] > 0 || hd[i] >= N) begin
          m_read[i[0]]  = 1'b0;
          m_write[i[0]] = 1'b0;
          if (gp[i] > 0) gp[i]--;
        end else begin
          m_address[i[0]]   = ca[i][hd[i]];
          m_writedata[i[0]] = cd[i][hd[i]];
          m_write[i[0]]     = cw[i][hd[i]];
          m_read[i[0]]      = !cw[i][hd[i]];
        end
      end
      s_waitrequest   = ($urandom_range(0, 3) == 0);
      rdv             = (due.size() > 0) && (due[0] <= cy);
      s_readdatavalid = rdv;
      s_readdata      = rdv ? rdq[0] : $urandom;
      #1;
      nacc = 0;
      who  = 0;
      for (int i = 0; i < 2; i++) begin
        if ((m_read[i[0]] || m_write[i[0]]) && !m_waitrequest[i[0]]) begin
          nacc++;
          who = i;
        end
      end
      sacc = (s_read || s_write) && !s_waitrequest;
      n_cmp++;
      if (nacc != int'(sacc)) begin
        n_bad++;
        $display("FAIL rnd_acc @%0d: masters=%0d slave=%0b", cy,
                 nacc, sacc);
      end
      if (sacc && nacc == 1) begin
        j = hd[who];
        n_cmp++;
        if (s_write !== cw[who][j] || s_read !== !cw[who][j]
            || s_address !== ca[who][j]
            || (cw[who][j] && s_writedata !== cd[who][j])) begin
          n_bad++;
          $display("FAIL rnd_cmd @%0d m%0d: wr=%b a=%h d=%h req %b %h %h",
                   cy, who, s_write, s_address, s_writedata,
                   cw[who][j], ca[who][j], cd[who][j]);
        end
      end
      erdv = rdv ? (2'b01 << rm[0]) : 2'b00;
      n_cmp++;
      if (m_readdatavalid !== erdv
          || (rdv && m_readdata !== rdq[0])) begin
        n_bad++;
        $display("FAIL rnd_ret @%0d: rdv=%b d=%h required %b",
                 cy, m_readdatavalid, m_readdata, erdv);
      end
      if (rdv) begin
        void'(due.pop_front());
        void'(rm.pop_front());
        void'(rdq.pop_front());
      end
      if (sacc && s_read) begin
        rm.push_back(who);
        rdq.push_back($urandom);
        d = cy + $urandom_range(1, 6);
        if (d <= lastdue) d = lastdue + 1;
        lastdue = d;
        due.push_back(d);
        n_cmp++;
        if (rm.size() > MAXP) begin
          n_bad++;
          $display("FAIL rnd_pend @%0d: pending=%0d max %0d",
                   cy, rm.size(), MAXP);
        end
      end
      tick();
      if (nacc == 1) begin
        hd[who]++;
        gp[who] = $urandom_range(0, 2);
      end
      done = (hd[0] == N) && (hd[1] == N) && (rm.size() == 0);
    end
    n_cmp++;
    if (!done || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rnd_end: done=%0b err=%b required 1 0",
               done, err);
    end
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_fifo_full();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
